// File: rtl/aes_pkg.sv
// Shared AES definitions for the round datapath.
//   state_t / word_t : 128-bit state and 32-bit word types
//   AES_ROUNDS       : key-schedule steps for AES-128
//   RCON             : round constants for schedule steps 0..9
//   sbox()           : forward S-box lookup, shared with SubBytes
//   rcon_at()        : RCON lookup that yields 0 outside the table
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam int AES_ROUNDS = 10;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  // The counter can reach AES_ROUNDS, one past the table; no step is taken
  // there, so a zero constant is harmless.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    if (idx < 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/add_round_key_stage_if.sv
// Handshake bundle of add_round_key_stage.
//   key_load/cipher_key           : key load pulse and AES-128 key
//   state_in/state_valid/state_ready : upstream state handshake
//   state_out/out_valid/out_ready : downstream handshake
//   out_round/last_round          : round tag of state_out
// master = the side driving keys and states, slave = the stage.
interface add_round_key_stage_if;
  import aes_pkg::*;

  logic       key_load;
  state_t     cipher_key;
  state_t     state_in;
  logic       state_valid;
  logic       state_ready;
  state_t     state_out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_round;
  logic       last_round;

  modport master (
    output key_load, cipher_key, state_in, state_valid, out_ready,
    input  state_ready, state_out, out_valid, out_round, last_round
  );

  modport slave (
    input  key_load, cipher_key, state_in, state_valid, out_ready,
    output state_ready, state_out, out_valid, out_round, last_round
  );
endinterface

// File: rtl/key_expand_round.sv
// One AES-128 key-schedule step, purely combinational.
//   key_in  : current round key, w0 = [127:96]
//   rcon    : round constant for this step
//   key_out : next round key
module key_expand_round
  import aes_pkg::*;
(
  input  state_t     key_in,
  input  logic [7:0] rcon,
  output state_t     key_out
);

  word_t w0, w1, w2, w3;
  word_t rot, sub, t;
  word_t n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  // RotWord: leftmost byte moves to the right end.
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey stage with on-the-fly AES-128 key schedule.
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset
//   bus   : slave side of add_round_key_stage_if (key load, input state
//           handshake, registered output handshake with round tag)
// Each accepted state advances the schedule one step and is XORed with the
// resulting key; after NUM_ROUNDS steps the stage refuses input until the
// next key load.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input logic                  clk,
  input logic                  n_rst,
  add_round_key_stage_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS);

  state_t     round_key_q, round_key_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic       key_ok_q, key_ok_d;
  state_t     state_out_q, state_out_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_round_q, out_round_d;
  logic       last_round_q, last_round_d;

  state_t     next_key;
  logic       ready;
  logic       accept;

  key_expand_round u_kexp (
    .key_in  (round_key_q),
    .rcon    (rcon_at(round_cnt_q)),
    .key_out (next_key)
  );

  // A key load in this cycle blocks acceptance so a state never pairs with
  // a key from the schedule being abandoned.
  assign ready  = key_ok_q && !bus.key_load && (round_cnt_q < LAST_CNT) &&
                  (!out_valid_q || bus.out_ready);
  assign accept = bus.state_valid && ready;

  always_comb begin
    round_key_d  = round_key_q;
    round_cnt_d  = round_cnt_q;
    key_ok_d     = key_ok_q;
    state_out_d  = state_out_q;
    out_valid_d  = out_valid_q;
    out_round_d  = out_round_q;
    last_round_d = last_round_q;

    if (bus.key_load) begin
      round_key_d = bus.cipher_key;
      round_cnt_d = 4'd0;
      key_ok_d    = 1'b1;
    end else if (accept) begin
      round_key_d = next_key;
      round_cnt_d = round_cnt_q + 4'd1;
    end

    // Output register: new data wins over a simultaneous drain.
    if (accept) begin
      state_out_d  = bus.state_in ^ next_key;
      out_round_d  = round_cnt_q + 4'd1;
      last_round_d = (round_cnt_q + 4'd1 == LAST_CNT);
      out_valid_d  = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      round_key_q  <= '0;
      round_cnt_q  <= '0;
      key_ok_q     <= 1'b0;
      state_out_q  <= '0;
      out_valid_q  <= 1'b0;
      out_round_q  <= '0;
      last_round_q <= 1'b0;
    end else begin
      round_key_q  <= round_key_d;
      round_cnt_q  <= round_cnt_d;
      key_ok_q     <= key_ok_d;
      state_out_q  <= state_out_d;
      out_valid_q  <= out_valid_d;
      out_round_q  <= out_round_d;
      last_round_q <= last_round_d;
    end
  end

  assign bus.state_ready = ready;
  assign bus.state_out   = state_out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_round   = out_round_q;
  assign bus.last_round  = last_round_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Self-checking bench for add_round_key_stage: randomized and directed
// stimulus against a transaction-level model holding the full FIPS-197 key
// schedule, with an S-box derived from GF(2^8) inversion.
module tb_add_round_key_stage;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  add_round_key_stage_if bus ();

  add_round_key_stage dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   ref_sbox [0:255];
  logic [127:0] m_sched  [0:10];
  logic         m_key_ok;
  int           m_cnt;
  logic         m_ov;
  logic [127:0] m_out;
  int           m_round;
  logic         m_last;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                    rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_sched(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {ref_sbox[tmp[23:16]], ref_sbox[tmp[15:8]],
               ref_sbox[tmp[7:0]],   ref_sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++)
      m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_key_ok = 1'b0;
    m_cnt    = 0;
    m_ov     = 1'b0;
    m_out    = '0;
    m_round  = 0;
    m_last   = 1'b0;
    for (int r = 0; r <= 10; r++) m_sched[r] = '0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid",  128'(bus.out_valid),  128'(m_ov));
    chk("state_out",  bus.state_out,        m_out);
    chk("out_round",  128'(bus.out_round),  128'(m_round));
    chk("last_round", 128'(bus.last_round), 128'(m_last));
  endtask

  // Called just after a falling edge with inputs already driven. Checks the
  // ready output, advances the model over the rising edge, then checks the
  // registered outputs at the next falling edge.
  task automatic tick();
    logic         exp_rdy, acc, drn, kl;
    logic [127:0] ck, si;
    #1;
    exp_rdy = m_key_ok && !bus.key_load && (m_cnt < 10) && (!m_ov || bus.out_ready);
    chk("state_ready", 128'(bus.state_ready), 128'(exp_rdy));
    acc = bus.state_valid && exp_rdy;
    drn = m_ov && bus.out_ready;
    kl  = bus.key_load;
    ck  = bus.cipher_key;
    si  = bus.state_in;
    @(posedge clk);
    if (acc) begin
      m_out   = si ^ m_sched[m_cnt + 1];
      m_round = m_cnt + 1;
      m_last  = (m_cnt + 1 == 10);
      m_ov    = 1'b1;
      m_cnt   = m_cnt + 1;
    end else if (drn) begin
      m_ov = 1'b0;
    end
    if (kl) begin
      build_sched(ck);
      m_cnt    = 0;
      m_key_ok = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    checks   = 0;
    failures = 0;
    build_sbox();
    model_reset();
    n_rst           = 1'b0;
    bus.key_load    = 1'b0;
    bus.cipher_key  = '0;
    bus.state_in    = '0;
    bus.state_valid = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_ready", 128'(bus.state_ready), 128'(0));
    n_rst = 1'b1;

    // States before any key load are refused
    bus.state_valid = 1'b1;
    bus.state_in    = rnd128();
    repeat (3) tick();

    // Key load with a state present: no accept that cycle, accept the next
    bus.key_load   = 1'b1;
    bus.cipher_key = KEY_A;
    bus.state_in   = '0;
    tick();
    bus.key_load = 1'b0;
    tick();
    chk("kat_r1", bus.state_out, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat_r1_round", 128'(bus.out_round), 128'(1));
    chk("kat_r1_last", 128'(bus.last_round), 128'(0));

    // Nine more back-to-back zero states, then exhaustion
    repeat (9) tick();
    chk("kat_r10", bus.state_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("kat_r10_last", 128'(bus.last_round), 128'(1));
    chk("kat_r10_round", 128'(bus.out_round), 128'(10));
    repeat (3) tick();

    // Backpressure: output held for 5 cycles, then flow resumes
    bus.key_load    = 1'b1;
    bus.cipher_key  = rnd128();
    bus.state_valid = 1'b0;
    tick();
    bus.key_load    = 1'b0;
    bus.state_valid = 1'b1;
    bus.state_in    = rnd128();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.state_in = rnd128();
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.state_in = rnd128();
      tick();
    end
    chk("bp_round", 128'(bus.out_round), 128'(5));

    // Mid-schedule reload with a pending round-4 output
    bus.key_load    = 1'b1;
    bus.cipher_key  = rnd128();
    bus.state_valid = 1'b0;
    tick();
    bus.key_load    = 1'b0;
    bus.state_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.state_in = rnd128();
      tick();
    end
    bus.out_ready  = 1'b0;
    bus.key_load   = 1'b1;
    bus.cipher_key = rnd128();
    bus.state_in   = rnd128();
    tick();
    chk("pend_round", 128'(bus.out_round), 128'(4));
    bus.key_load  = 1'b0;
    bus.out_ready = 1'b1;
    bus.state_in  = rnd128();
    tick();
    chk("reload_round", 128'(bus.out_round), 128'(1));

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bus.key_load    = ($urandom_range(0, 19) == 0);
      bus.cipher_key  = rnd128();
      bus.state_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.state_in    = rnd128();
      tick();
    end

    // Asynchronous reset while an output is pending
    bus.key_load    = 1'b1;
    bus.cipher_key  = rnd128();
    bus.state_valid = 1'b0;
    bus.out_ready   = 1'b1;
    tick();
    bus.key_load    = 1'b0;
    bus.state_valid = 1'b1;
    bus.state_in    = rnd128();
    tick();
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_async_ready", 128'(bus.state_ready), 128'(0));
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Diffusion-layer consumer. Takes the 128-bit state produced by the MixColumns stage, or the ShiftRows stage in the final round, and XORs it with the current round key.
- Generates round keys on the fly: one key-schedule step per accepted state, from a cipher key loaded once per block.
- Output is registered behind a valid/ready handshake and feeds the next round's SubBytes, or the ciphertext capture.

Parameters:
NUM_ROUNDS, 10, number of key-schedule steps before the stage stops accepting states (AES-128).

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
key_load  input  1  single-cycle pulse; loads cipher_key as round key 0
cipher_key  input  128  AES-128 key; word w0 = [127:96], byte 0 = [127:120] (FIPS-197 order)
state_in  input  128  state from the diffusion layer; column c = [127-32c -: 32]
state_valid  input  1  state_in valid
state_ready  output  1  stage can accept state_in this cycle
state_out  output  128  state_in XOR round key, registered
out_valid  output  1  state_out valid
out_ready  input  1  downstream accepts state_out
out_round  output  4  round index (1..NUM_ROUNDS) of state_out
last_round  output  1  high with out_valid when out_round == NUM_ROUNDS

Behaviour:
- Reset values: state_out = 0, out_valid = 0, out_round = 0, last_round = 0. Internal state also resets: round key = 0, round_cnt = 0, key_ok = 0.
- Key load: on a key_load cycle, round_key <= cipher_key, round_cnt <= 0, key_ok <= 1.
  - Does not flush the output register; a pending out_valid stays until taken.
- state_ready = key_ok && !key_load && (round_cnt < NUM_ROUNDS) && (!out_valid || out_ready). Combinational, with no dependence on state_valid.
- Accept = state_valid && state_ready. On accept:
  - next_key = expand(round_key, rcon[round_cnt])
  - state_out <= state_in ^ next_key
  - round_key <= next_key
  - round_cnt <= round_cnt + 1
  - out_round <= round_cnt + 1
  - last_round <= (round_cnt + 1 == NUM_ROUNDS)
  - out_valid <= 1
- Latency: exactly 1 cycle from accept to out_valid. Full throughput of one state per cycle while out_ready stays high.
- Output register:
  - out_valid && out_ready with no accept in the same cycle clears out_valid.
  - Accept and drain in the same cycle keeps out_valid = 1 and loads new data.
  - While out_valid && !out_ready, state_out, out_round and last_round hold stable.
- expand(k, rc):
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}
  - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  - rcon[0..9] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Exhaustion: once round_cnt == NUM_ROUNDS, state_ready stays 0 until the next key_load. state_valid held high in this condition is ignored, with no error flag.
- key_load with key_ok already set restarts the schedule at round 0. Any state presented in that same cycle is not accepted.
- States presented before the first key_load are not accepted, because key_ok = 0.
- Reset asserted mid-operation clears everything immediately, including any pending output.
- Round-0 whitening (plaintext ^ cipher_key) is not performed here; it belongs to the input stage.

Decomposition:
- Shared package aes_pkg holds:
  - typedefs state_t (128-bit) and word_t (32-bit)
  - AES_ROUNDS = 10
  - the RCON constant array
  - the S-box function or constant table shared with SubBytes
- One sub-module, key_expand_round: combinational, inputs key_in[127:0] and rcon[7:0], output key_out[127:0]. It instantiates 4 S-box lookups.
- The top level holds the handshake, the counter and the registers.

Test Plan:
- Reset then key_load with cipher_key = 2b7e151628aed2a6abf7158809cf4f3c; state_in = 0 valid with out_ready = 1 -> the next cycle gives state_out = a0fafe1788542cb123a339392a6c7605, out_round = 1, last_round = 0.
- Same key, 10 back-to-back zero states -> out_valid on 10 consecutive cycles; the tenth gives state_out = d014f9a8c9ee2589e13f0cc8b6630ca6 with last_round = 1; state_ready drops to 0 after the tenth accept.
- Backpressure: out_ready = 0 after the first accept -> state_ready = 0; state_out stays stable for 5 cycles; when out_ready rises, accept resumes with no lost or duplicated round.
- state_valid before any key_load -> state_ready = 0 and out_valid stays 0; key_load with state_valid high in the same cycle -> no accept that cycle, accept on the next.
- Mid-schedule key_load (after round 4) -> the next accept uses the round-1 key of the new key; the pending round-4 output still drains intact.
- n_rst asserted while out_valid = 1 -> all outputs are 0 asynchronously; after release, state_ready = 0 until key_load.
